// File: rtl/max7000_config_loader.sv
// Streams a MAX7000 configuration bitstream in over valid/ready, verifies a trailing XOR
// checksum word and commits it atomically to a double-buffered bitstream output.
module max7000_config_loader #(
  parameter int LAB_COUNT            = 2,
  parameter int MACROCELLS_PER_LAB   = 16,
  parameter int PTERMS_PER_MACROCELL = 5,
  parameter int PIA_SIGNALS_PER_LAB  = 36,
  parameter int MACROCELL_BITS       = 13,
  parameter int ROUTING_BITS_PER_LAB = 144,
  parameter int WORD_WIDTH           = 8,
  localparam int PT_BITS    = 2*PIA_SIGNALS_PER_LAB + MACROCELLS_PER_LAB,
  localparam int TOTAL_BITS = LAB_COUNT*MACROCELLS_PER_LAB*(PTERMS_PER_MACROCELL*PT_BITS + MACROCELL_BITS)
                              + LAB_COUNT*ROUTING_BITS_PER_LAB,
  localparam int WORDS      = TOTAL_BITS / WORD_WIDTH,
  localparam int COUNT_W    = $clog2(WORDS+1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic [TOTAL_BITS-1:0] bitstream,
  output logic                  config_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [COUNT_W-1:0]    word_count
);

  if ((TOTAL_BITS % WORD_WIDTH) != 0) begin : g_bad_word_width
    $error("max7000_config_loader: TOTAL_BITS must be a multiple of WORD_WIDTH");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  state_t                  state;
  logic [TOTAL_BITS-1:0]   shadow;
  logic [WORD_WIDTH-1:0]   csum;

  assign data_ready = (state == LOAD) || (state == CHECK);
  assign busy       = data_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      shadow       <= '0;
      bitstream    <= '0;
      csum         <= '0;
      word_count   <= '0;
      config_valid <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state      <= LOAD;
            word_count <= '0;
            csum       <= '0;
            error      <= 1'b0;
          end
        end
        LOAD: begin
          if (start) begin
            // restart wins over a word offered in the same cycle
            word_count <= '0;
            csum       <= '0;
          end else if (data_valid) begin
            // shifting in MSB-first leaves word 0 at the top once all WORDS have arrived
            shadow     <= (shadow << WORD_WIDTH) | TOTAL_BITS'(data_in);
            csum       <= csum ^ data_in;
            word_count <= word_count + COUNT_W'(1);
            if (word_count == COUNT_W'(WORDS-1)) begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (start) begin
            state      <= LOAD;
            word_count <= '0;
            csum       <= '0;
          end else if (data_valid) begin
            if (data_in == csum) begin
              state        <= DONE;
              bitstream    <= shadow;
              config_valid <= 1'b1;
              done         <= 1'b1;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
